// File: rtl/gppcu_cmd_sequencer.sv
// Host-to-GPPCU command sequencer: queues host requests and replays each one as a
// setup / strobe / hold cycle sequence on the GPPCU command port, collecting read data for LMEM reads.
module gppcu_cmd_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int HIGH_CYC   = 1,
    parameter int RD_LAT     = 2
) (
    input  logic        iACLK,
    input  logic        inRST,
    input  logic        iREQ_VALID,
    output logic        oREQ_READY,
    input  logic [1:0]  iREQ_OP,
    input  logic [7:0]  iREQ_THREAD,
    input  logic [15:0] iREQ_ADDR,
    input  logic [31:0] iREQ_DATA,
    output logic        oRSP_VALID,
    input  logic        iRSP_READY,
    output logic [31:0] oRSP_DATA,
    output logic [31:0] oCMD,
    output logic [31:0] oDATA,
    input  logic [31:0] iDATA,
    input  logic        iFULL,
    output logic        oBUSY,
    output logic [15:0] oSTALL_CNT
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int EW      = 2 + 8 + 16 + 32;
    localparam int CNT_MAX = (HIGH_CYC > RD_LAT) ? HIGH_CYC : RD_LAT;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [AW:0]   PTR_ONE   = 1;
    localparam logic [CW-1:0] CNT_ONE   = 1;
    localparam logic [CW-1:0] HIGH_LAST = CW'(HIGH_CYC - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(RD_LAT - 1);
    localparam logic [1:0]    OP_PUSH   = 2'd0;
    localparam logic [1:0]    OP_READ   = 2'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_WAIT,
        S_RSP
    } state_e;

    state_e          state_q, state_d;
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic [EW-1:0]   fifo_mem_q [FIFO_DEPTH];
    logic [EW-1:0]   fifo_head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            rdy_en_q;

    logic [1:0]      op_q;
    logic [7:0]      thread_q;
    logic [15:0]     addr_q;
    logic [31:0]     data_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [15:0]     stall_q, stall_d;
    logic [31:0]     rsp_data_q;
    logic            capture;
    logic [30:0]     cmd_fields;

    // Request FIFO: the extra pointer bit distinguishes full from empty.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign oREQ_READY = rdy_en_q & ~fifo_full;
    assign push       = iREQ_VALID & oREQ_READY;
    assign pop        = (state_q == S_IDLE) & ~fifo_empty;
    assign wr_ptr_d   = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    assign rd_ptr_d   = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    assign fifo_head  = fifo_mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge iACLK) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q[AW-1:0]] <= {iREQ_OP, iREQ_THREAD, iREQ_ADDR, iREQ_DATA};
        end
    end

    always_ff @(posedge iACLK) begin
        if (pop) begin
            {op_q, thread_q, addr_q, data_q} <= fifo_head;
        end
    end

    // rdy_en_q keeps the host port closed until the first edge after reset release.
    always_ff @(posedge iACLK or negedge inRST) begin
        if (!inRST) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            stall_q    <= '0;
            rsp_data_q <= '0;
            rdy_en_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            stall_q  <= stall_d;
            rdy_en_q <= 1'b1;
            if (capture) begin
                rsp_data_q <= iDATA;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_d = stall_q;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                // Only instruction pushes back off on a full GPPCU queue.
                if ((op_q == OP_PUSH) && iFULL) begin
                    if (stall_q != 16'hFFFF) begin
                        stall_d = stall_q + 16'd1;
                    end
                end else begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end
            end
            S_HIGH: begin
                if (cnt_q == HIGH_LAST) begin
                    state_d = S_LOW;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_LOW: begin
                cnt_d   = '0;
                state_d = (op_q == OP_READ) ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    capture = 1'b1;
                    state_d = S_RSP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_RSP: begin
                if (iRSP_READY) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cmd_fields = {5'b0, op_q, thread_q, addr_q};

    always_comb begin
        oCMD  = '0;
        oDATA = '0;
        case (state_q)
            S_SETUP, S_LOW, S_WAIT: begin
                oCMD  = {1'b0, cmd_fields};
                oDATA = data_q;
            end
            S_HIGH: begin
                oCMD  = {1'b1, cmd_fields};
                oDATA = data_q;
            end
            default: begin
                oCMD  = '0;
                oDATA = '0;
            end
        endcase
    end

    assign oRSP_VALID = (state_q == S_RSP);
    assign oRSP_DATA  = rsp_data_q;
    assign oBUSY      = (state_q != S_IDLE) | ~fifo_empty;
    assign oSTALL_CNT = stall_q;

endmodule

// File: tb/tb_gppcu_cmd_sequencer.sv
// Bench for gppcu_cmd_sequencer: vector table of single requests, hand-written corner
// sequences, and a randomized phase scored against a queue-based request/response model.
module tb_gppcu_cmd_sequencer;

    localparam int FIFO_DEPTH = 4;
    localparam int HIGH_CYC   = 1;
    localparam int RD_LAT     = 2;

    logic        iACLK;
    logic        inRST;
    logic        iREQ_VALID;
    logic        oREQ_READY;
    logic [1:0]  iREQ_OP;
    logic [7:0]  iREQ_THREAD;
    logic [15:0] iREQ_ADDR;
    logic [31:0] iREQ_DATA;
    logic        oRSP_VALID;
    logic        iRSP_READY;
    logic [31:0] oRSP_DATA;
    logic [31:0] oCMD;
    logic [31:0] oDATA;
    logic [31:0] iDATA;
    logic        iFULL;
    logic        oBUSY;
    logic [15:0] oSTALL_CNT;

    gppcu_cmd_sequencer #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .HIGH_CYC  (HIGH_CYC),
        .RD_LAT    (RD_LAT)
    ) dut (
        .iACLK      (iACLK),
        .inRST      (inRST),
        .iREQ_VALID (iREQ_VALID),
        .oREQ_READY (oREQ_READY),
        .iREQ_OP    (iREQ_OP),
        .iREQ_THREAD(iREQ_THREAD),
        .iREQ_ADDR  (iREQ_ADDR),
        .iREQ_DATA  (iREQ_DATA),
        .oRSP_VALID (oRSP_VALID),
        .iRSP_READY (iRSP_READY),
        .oRSP_DATA  (oRSP_DATA),
        .oCMD       (oCMD),
        .oDATA      (oDATA),
        .iDATA      (iDATA),
        .iFULL      (iFULL),
        .oBUSY      (oBUSY),
        .oSTALL_CNT (oSTALL_CNT)
    );

    initial iACLK = 1'b0;
    always #5 iACLK = ~iACLK;

    typedef struct packed {
        logic [1:0]  op;
        logic [7:0]  thread;
        logic [15:0] addr;
        logic [31:0] data;
    } req_t;

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  thread;
        logic [15:0] addr;
        logic [31:0] data;
        int          full_cyc;
        bit          full_in_high;
        logic [31:0] rdata;
        logic [31:0] exp_cmd;
        int          exp_stall;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          nstrobe = 0;
    int          rise = 0;
    int          width = 0;
    bit          mon_en = 1'b0;
    logic        prev_s = 1'b0;
    req_t        cur;
    req_t        exp_q[$];
    int          rsp_idx_q[$];
    logic [31:0] hist[int];
    vec_t        vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard step: strobes must appear in request order, one at a time, and
    // each read returns the iDATA value present in its last wait cycle.
    task automatic mon_step();
        logic s;
        int   idx;
        s = oCMD[31];
        if (s && !prev_s) begin
            nstrobe++;
            chk("mon_overlap", 32'(rsp_idx_q.size()), 32'd0);
            if (exp_q.size() == 0) begin
                chk("mon_unexpected_strobe", oCMD, 32'd0);
            end else begin
                cur = exp_q.pop_front();
                chk("mon_strobe_cmd", oCMD, {1'b1, 5'b0, cur.op, cur.thread, cur.addr});
                chk("mon_strobe_data", oDATA, cur.data);
            end
            rise  = cyc;
            width = 0;
        end
        if (s) width++;
        if (!s && prev_s) begin
            chk("mon_strobe_width", 32'(width), 32'(HIGH_CYC));
            chk("mon_low_cmd", oCMD, {1'b0, 5'b0, cur.op, cur.thread, cur.addr});
            chk("mon_low_data", oDATA, cur.data);
            if (cur.op == 2'd1) rsp_idx_q.push_back(rise + HIGH_CYC + RD_LAT);
        end
        prev_s = s;
        iRSP_READY = ($urandom_range(0, 2) != 0);
        if (oRSP_VALID && iRSP_READY) begin
            if (rsp_idx_q.size() == 0) begin
                chk("mon_unexpected_rsp", 32'd1, 32'd0);
            end else begin
                idx = rsp_idx_q.pop_front();
                chk("mon_rsp_data", oRSP_DATA, hist.exists(idx) ? hist[idx] : 32'hxxxxxxxx);
            end
        end
        iDATA = $urandom;
        hist[cyc] = iDATA;
    endtask

    task automatic tick();
        @(negedge iACLK);
        cyc++;
        if (mon_en) mon_step();
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        int w;
        int stall0;
        chk({tag, "_ready"}, 32'(oREQ_READY), 32'd1);
        stall0      = int'(oSTALL_CNT);
        iREQ_VALID  = 1'b1;
        iREQ_OP     = v.op;
        iREQ_THREAD = v.thread;
        iREQ_ADDR   = v.addr;
        iREQ_DATA   = v.data;
        iFULL       = (v.full_cyc > 0);
        tick();
        iREQ_VALID  = 1'b0;
        lat = 1;
        while (!oCMD[31] && lat < 100) begin
            if (lat == 2) begin
                chk({tag, "_setup_cmd"}, oCMD, v.exp_cmd & 32'h7FFF_FFFF);
                chk({tag, "_setup_data"}, oDATA, v.data);
            end
            if (v.op == 2'd0 && iFULL && (int'(oSTALL_CNT) - stall0) == v.full_cyc) iFULL = 1'b0;
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(3 + v.exp_stall));
        if (v.full_in_high) iFULL = 1'b1;
        w = 0;
        while (oCMD[31] && w < 100) begin
            chk({tag, "_high_cmd"}, oCMD, v.exp_cmd);
            chk({tag, "_high_data"}, oDATA, v.data);
            w++;
            tick();
        end
        chk({tag, "_width"}, 32'(w), 32'(HIGH_CYC));
        chk({tag, "_low_cmd"}, oCMD, v.exp_cmd & 32'h7FFF_FFFF);
        chk({tag, "_low_data"}, oDATA, v.data);
        if (v.op == 2'd1) begin
            for (int i = 0; i <= RD_LAT; i++) begin
                iDATA = (i == RD_LAT) ? v.rdata : ~v.rdata;
                tick();
            end
            iDATA = ~v.rdata;
            for (int k = 0; k < 3; k++) begin
                chk({tag, "_rsp_valid"}, 32'(oRSP_VALID), 32'd1);
                chk({tag, "_rsp_data"}, oRSP_DATA, v.rdata);
                tick();
            end
            iRSP_READY = 1'b1;
            tick();
            iRSP_READY = 1'b0;
            chk({tag, "_rsp_done"}, 32'(oRSP_VALID), 32'd0);
        end else begin
            for (int k = 0; k < 3; k++) begin
                chk({tag, "_no_rsp"}, 32'(oRSP_VALID), 32'd0);
                tick();
            end
        end
        iFULL = 1'b0;
        chk({tag, "_stall_delta"}, 32'(int'(oSTALL_CNT) - stall0), 32'(v.exp_stall));
        for (int g = 0; g < 50 && oBUSY; g++) tick();
        chk({tag, "_idle"}, 32'(oBUSY), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached total=%0d", total);
        $fatal(1, "watchdog expired");
    end

    initial begin
        req_t r;
        req_t b2b[6];
        vec_t vw;
        int   pushed;
        int   first_nr;
        int   g;
        bit   clean;

        vecs[0] = '{2'd0, 8'h00, 16'h0000, 32'hDEADBEEF, 0,  1'b0, 32'h0,        32'h8000_0000, 0};
        vecs[1] = '{2'd1, 8'h05, 16'h0010, 32'h0000_0000, 0, 1'b0, 32'h12345678, 32'h8105_0010, 0};
        vecs[2] = '{2'd0, 8'h3C, 16'hBEEF, 32'h0BADF00D, 10, 1'b0, 32'h0,        32'h803C_BEEF, 10};
        vecs[3] = '{2'd2, 8'hFF, 16'hFFFF, 32'hCAFEF00D, 0,  1'b0, 32'h0,        32'h82FF_FFFF, 0};
        vecs[4] = '{2'd3, 8'h01, 16'h1234, 32'h55AA55AA, 3,  1'b0, 32'h0,        32'h8301_1234, 0};
        vecs[5] = '{2'd1, 8'h80, 16'hFFFF, 32'h0000_0001, 2, 1'b0, 32'hA5A50F0F, 32'h8180_FFFF, 0};
        vecs[6] = '{2'd0, 8'h22, 16'h0F0F, 32'h13579BDF, 0,  1'b1, 32'h0,        32'h8022_0F0F, 0};

        iREQ_VALID = 1'b0; iREQ_OP = '0; iREQ_THREAD = '0; iREQ_ADDR = '0; iREQ_DATA = '0;
        iRSP_READY = 1'b0; iDATA = '0; iFULL = 1'b0;
        inRST = 1'b1;
        #1 inRST = 1'b0;
        #1;
        chk("rst_async_cmd", oCMD, 32'd0);
        chk("rst_async_ready", 32'(oREQ_READY), 32'd0);
        repeat (3) @(negedge iACLK);
        chk("rst_cmd", oCMD, 32'd0);
        chk("rst_data", oDATA, 32'd0);
        chk("rst_rsp_valid", 32'(oRSP_VALID), 32'd0);
        chk("rst_rsp_data", oRSP_DATA, 32'd0);
        chk("rst_stall", 32'(oSTALL_CNT), 32'd0);
        chk("rst_ready", 32'(oREQ_READY), 32'd0);
        chk("rst_busy", 32'(oBUSY), 32'd0);
        inRST = 1'b1;
        tick();
        chk("post_rst_ready", 32'(oREQ_READY), 32'd1);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Six queued requests: ready must drop with four entries waiting.
        b2b[0] = '{2'd0, 8'h10, 16'h0001, 32'h1000_0001};
        b2b[1] = '{2'd2, 8'h11, 16'h0002, 32'h1000_0002};
        b2b[2] = '{2'd3, 8'h12, 16'h0003, 32'h1000_0003};
        b2b[3] = '{2'd0, 8'h13, 16'h0004, 32'h1000_0004};
        b2b[4] = '{2'd3, 8'h14, 16'h0005, 32'h1000_0005};
        b2b[5] = '{2'd2, 8'h15, 16'h0006, 32'h1000_0006};
        mon_en = 1'b1; prev_s = 1'b0; nstrobe = 0;
        pushed = 0; first_nr = -1; g = 0;
        while (pushed < 6 && g < 200) begin
            if (!oREQ_READY && first_nr < 0) first_nr = pushed;
            iREQ_VALID  = 1'b1;
            iREQ_OP     = b2b[pushed].op;
            iREQ_THREAD = b2b[pushed].thread;
            iREQ_ADDR   = b2b[pushed].addr;
            iREQ_DATA   = b2b[pushed].data;
            if (oREQ_READY) begin
                exp_q.push_back(b2b[pushed]);
                pushed++;
            end
            tick();
            g++;
        end
        iREQ_VALID = 1'b0;
        chk("b2b_ready_drop_at", 32'(first_nr), 32'd5);
        for (int k = 0; k < 200 && (exp_q.size() != 0 || oBUSY); k++) tick();
        chk("b2b_strobes", 32'(nstrobe), 32'd6);
        chk("b2b_left", 32'(exp_q.size()), 32'd0);

        pushed = 0; g = 0;
        while (pushed < 60 && g < 5000) begin
            iFULL = ($urandom_range(0, 3) == 0);
            r.op = 2'($urandom_range(0, 3));
            r.thread = 8'($urandom);
            r.addr = 16'($urandom);
            r.data = $urandom;
            iREQ_VALID  = ($urandom_range(0, 9) < 7);
            iREQ_OP     = r.op;
            iREQ_THREAD = r.thread;
            iREQ_ADDR   = r.addr;
            iREQ_DATA   = r.data;
            if (iREQ_VALID && oREQ_READY) begin
                exp_q.push_back(r);
                pushed++;
            end
            tick();
            g++;
        end
        iREQ_VALID = 1'b0;
        iFULL = 1'b0;
        for (int k = 0; k < 3000 && (exp_q.size() != 0 || rsp_idx_q.size() != 0 || oBUSY); k++) tick();
        chk("rand_pushed", 32'(pushed), 32'd60);
        chk("rand_req_left", 32'(exp_q.size()), 32'd0);
        chk("rand_rsp_left", 32'(rsp_idx_q.size()), 32'd0);
        chk("rand_idle", 32'(oBUSY), 32'd0);
        mon_en = 1'b0;
        iRSP_READY = 1'b0;
        tick();

        // Reset in the middle of a read strobe, with a write still queued.
        iREQ_VALID = 1'b1; iREQ_OP = 2'd1; iREQ_THREAD = 8'h07; iREQ_ADDR = 16'h0040; iREQ_DATA = 32'h0;
        tick();
        iREQ_OP = 2'd2; iREQ_THREAD = 8'h09; iREQ_ADDR = 16'h0050; iREQ_DATA = 32'h11112222;
        tick();
        iREQ_VALID = 1'b0;
        for (int k = 0; k < 20 && !oCMD[31]; k++) tick();
        chk("abort_strobe_seen", 32'(oCMD[31]), 32'd1);
        #2 inRST = 1'b0;
        #1;
        chk("abort_cmd", oCMD, 32'd0);
        chk("abort_data", oDATA, 32'd0);
        chk("abort_rsp_valid", 32'(oRSP_VALID), 32'd0);
        chk("abort_rsp_data", oRSP_DATA, 32'd0);
        chk("abort_stall", 32'(oSTALL_CNT), 32'd0);
        chk("abort_ready", 32'(oREQ_READY), 32'd0);
        chk("abort_fifo_empty", 32'(oBUSY), 32'd0);
        tick();
        tick();
        inRST = 1'b1;
        clean = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (oRSP_VALID || oCMD != 32'd0 || oBUSY) clean = 1'b0;
        end
        chk("abort_quiet", 32'(clean), 32'd1);
        vw = '{2'd2, 8'h09, 16'h0050, 32'h11112222, 0, 1'b0, 32'h0, 32'h8209_0050, 0};
        run_vec(vw, "post_abort_write");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gppcu_cmd_sequencer.md
GPPCU_CMD_SEQUENCER -- requirements
Module: gppcu_cmd_sequencer

Interface
REQ-001 Parameters SHALL be, one per line:
  FIFO_DEPTH  4  request FIFO entries; power of 2, minimum 2
  HIGH_CYC    1  cycles the command strobe oCMD[31] is held high, minimum 1
  RD_LAT      2  cycles from the strobe falling edge to read-data capture, minimum 1
REQ-002 Ports SHALL be, one per line:
  iACLK        in   1   sole clock; all state updates on rising edge
  inRST        in   1   asynchronous, active-low reset
  iREQ_VALID   in   1   host request valid
  oREQ_READY   out  1   request accepted when both valid and ready are high
  iREQ_OP      in   2   0 PUSH INSTR, 1 READ LMEM, 2 WRITE LMEM, 3 SET GMEM
  iREQ_THREAD  in   8   thread select
  iREQ_ADDR    in   16  local/global address
  iREQ_DATA    in   32  instruction or write data
  oRSP_VALID   out  1   read response valid
  iRSP_READY   in   1   read response accept
  oRSP_DATA    out  32  read response data
  oCMD         out  32  {strobe, 5'b0, op[1:0], thread[7:0], addr[15:0]} to GPPCU command port
  oDATA        out  32  write/instruction data to GPPCU
  iDATA        in   32  read data from GPPCU
  iFULL        in   1   GPPCU instruction queue full
  oBUSY        out  1   FSM not in IDLE, or FIFO not empty
  oSTALL_CNT   out  16  saturating count of cycles stalled on iFULL
REQ-003 One clock (iACLK) SHALL be used; reset inRST SHALL be asynchronous and active-low.

Function
REQ-004 The request FIFO SHALL store {op, thread, addr, data}; oREQ_READY = FIFO not full; readiness SHALL NOT depend on a same-cycle pop.
REQ-005 FSM states SHALL be IDLE, SETUP, HIGH, LOW, WAIT and RSP.
REQ-006 IDLE with FIFO non-empty: pop the head into the working register and go to SETUP next cycle; oCMD=0 and oDATA=0 while in IDLE.
REQ-007 SETUP: oCMD fields and oDATA driven from the working register with strobe=0.
REQ-008 SETUP exit: if op=0 and iFULL=1, stay in SETUP and increment oSTALL_CNT, saturating at 16'hFFFF; otherwise go to HIGH.
REQ-009 HIGH: strobe=1 for exactly HIGH_CYC cycles with fields and data unchanged, then go to LOW.
REQ-010 LOW: strobe=0 for 1 cycle with fields held (hold time); then go to WAIT if op=1, else go to IDLE.
REQ-011 WAIT: count RD_LAT cycles, then on the last WAIT cycle register iDATA into oRSP_DATA and go to RSP.
REQ-012 RSP: oRSP_VALID=1 with oRSP_DATA stable until iRSP_READY=1; that cycle go to IDLE with oRSP_VALID=0 next.
REQ-013 Requests SHALL execute strictly in FIFO order, one at a time, with no overlap of strobes.
REQ-014 Minimum non-read request latency from acceptance to the next strobe-eligible pop: 1 (FIFO) + 1 (IDLE) + 1 (SETUP) + HIGH_CYC + 1 (LOW) cycles.
REQ-015 iFULL SHALL be sampled only in SETUP; a change of iFULL during HIGH or LOW SHALL be ignored.
REQ-016 Ops 2 and 3 SHALL complete without a response; op 1 always produces exactly one response.
REQ-017 FIFO pointers SHALL wrap modulo FIFO_DEPTH using one extra bit for full/empty; simultaneous push and pop SHALL keep the count unchanged.

Reset
REQ-018 inRST low SHALL immediately force: FSM to IDLE, FIFO empty, oCMD=0, oDATA=0, oRSP_VALID=0, oRSP_DATA=0, oSTALL_CNT=0, oREQ_READY=0.
REQ-019 After reset release: oREQ_READY=1 from the first clock edge; a reset asserted mid-operation SHALL abort the operation, drop any in-flight response, and never produce a partial strobe after assertion.

Verification
REQ-020 Push instr 0xDEADBEEF with iFULL=0 -> oCMD[31] high exactly HIGH_CYC cycles with oCMD[30:0]=0 and oDATA=0xDEADBEEF throughout SETUP/HIGH/LOW.
REQ-021 READ thread 5, addr 0x0010; drive iDATA=0x12345678 RD_LAT cycles after LOW -> oRSP_VALID with oRSP_DATA=0x12345678, held for 3 cycles while iRSP_READY=0.
REQ-022 iFULL=1 for 10 cycles during an instr push -> strobe withheld, oSTALL_CNT=10, strobe occurs after iFULL drops.
REQ-023 Issue 6 back-to-back requests with FIFO_DEPTH=4 -> oREQ_READY drops at 4 queued; all 6 execute in order with no lost or duplicated strobe.
REQ-024 Assert inRST during HIGH of a READ -> oCMD=0 asynchronously, no response; a subsequent WRITE executes normally.
